// File: rtl/vga_timing_gen.sv
// VGA raster timing driven by a one-cycle pixel strobe used as a clock enable.
// Level outputs are registered from next-count decode, so they track the counters with no lag.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW       = $clog2(H_TOTAL),
    localparam int VW       = $clog2(V_TOTAL)
) (
    input  logic          clk_i,
    input  logic          arstn_i,
    input  logic          pix_strb_i,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          de_o,
    output logic [HW-1:0] x_o,
    output logic [VW-1:0] y_o,
    output logic          line_start_o,
    output logic          frame_start_o
);

    generate
        if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_param
            $error("vga_timing_gen: every timing parameter must be >= 1");
        end
    endgenerate

    localparam logic          HS_ON   = (HSYNC_POL != 0);
    localparam logic          VS_ON   = (VSYNC_POL != 0);
    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_DE_E  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYN_S = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYN_E = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_DE_E  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYN_S = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYN_E = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          w_h_wrap;
    logic [HW-1:0] w_h_nxt;
    logic [VW-1:0] w_v_nxt;
    logic          w_hs_act;
    logic          w_vs_act;

    assign w_h_wrap = (r_h_cnt == H_LAST);
    assign w_h_nxt  = w_h_wrap ? '0 : r_h_cnt + HW'(1);
    assign w_v_nxt  = !w_h_wrap         ? r_v_cnt :
                      (r_v_cnt == V_LAST) ? '0 : r_v_cnt + VW'(1);
    assign w_hs_act = (w_h_nxt >= H_SYN_S) && (w_h_nxt < H_SYN_E);
    // vsync keys off the line counter only, so it spans whole lines starting at h = 0
    assign w_vs_act = (w_v_nxt >= V_SYN_S) && (w_v_nxt < V_SYN_E);

    // Counters start at the last position so the first strobe lands on (0,0)
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_h_cnt       <= H_LAST;
            r_v_cnt       <= V_LAST;
            hsync_o       <= ~HS_ON;
            vsync_o       <= ~VS_ON;
            de_o          <= 1'b0;
            x_o           <= '0;
            y_o           <= '0;
            line_start_o  <= 1'b0;
            frame_start_o <= 1'b0;
        end else begin
            line_start_o  <= 1'b0;
            frame_start_o <= 1'b0;
            if (pix_strb_i) begin
                r_h_cnt       <= w_h_nxt;
                r_v_cnt       <= w_v_nxt;
                x_o           <= w_h_nxt;
                y_o           <= w_v_nxt;
                de_o          <= (w_h_nxt < H_DE_E) && (w_v_nxt < V_DE_E);
                hsync_o       <= w_hs_act ? HS_ON : ~HS_ON;
                vsync_o       <= w_vs_act ? VS_ON : ~VS_ON;
                line_start_o  <= (w_h_nxt == '0);
                frame_start_o <= (w_h_nxt == '0) && (w_v_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench: small-raster instance checked every clock, default-raster instance spot-checked.
module tb_vga_timing_gen;

    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       arstn = 1'b0;
    logic       strb  = 1'b0;
    logic       hsync_o, vsync_o, de_o, line_start_o, frame_start_o;
    logic [2:0] x_o, y_o;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(0), .VSYNC_POL(0)
    ) u_dut (
        .clk_i(clk), .arstn_i(arstn), .pix_strb_i(strb),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
        .x_o(x_o), .y_o(y_o),
        .line_start_o(line_start_o), .frame_start_o(frame_start_o)
    );

    logic       d_rstn = 1'b0;
    logic       d_strb = 1'b0;
    logic       d_hs, d_vs, d_de, d_ls, d_fs;
    logic [9:0] d_x, d_y;

    vga_timing_gen u_dut_dflt (
        .clk_i(clk), .arstn_i(d_rstn), .pix_strb_i(d_strb),
        .hsync_o(d_hs), .vsync_o(d_vs), .de_o(d_de),
        .x_o(d_x), .y_o(d_y),
        .line_start_o(d_ls), .frame_start_o(d_fs)
    );

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [2:0] x;
        logic [2:0] y;
        logic       ls;
        logic       fs;
    } obs_t;

    localparam obs_t RST_OBS = '{1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0};

    obs_t act;
    assign act = {hsync_o, vsync_o, de_o, x_o, y_o, line_start_o, frame_start_o};

    obs_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;
    bit   d_done = 1'b0;
    int   mh, mv;

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, a, e, $time);
        end
    endtask

    function automatic obs_t mk(input int h, input int v);
        obs_t o;
        o.hs = !((h >= HA + HF) && (h < HA + HF + HS));
        o.vs = !((v >= VA + VF) && (v < VA + VF + VS));
        o.de = (h < HA) && (v < VA);
        o.x  = 3'(h);
        o.y  = 3'(v);
        o.ls = (h == 0);
        o.fs = (h == 0) && (v == 0);
        return o;
    endfunction

    // Called at a negedge; returns at a negedge after the requested idle clocks
    task automatic strobe(input int idle);
        strb = 1'b1;
        if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
            mh = mh + 1;
        end
        q.push_back(mk(mh, mv));
        @(negedge clk);
        strb = 1'b0;
        repeat (idle) @(negedge clk);
    endtask

    // Reset is asserted between clock edges to show it takes effect without one
    task automatic do_reset();
        mon_en = 1'b0;
        repeat (2) @(negedge clk);
        check("queue_drained", q.size(), 0);
        q.delete();
        @(posedge clk);
        #2 arstn = 1'b0;
        #1 check("async_reset", act, RST_OBS);
        @(negedge clk);
        check("reset_hold", act, RST_OBS);
        arstn = 1'b1;
        mh = HT - 1;
        mv = VT - 1;
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    initial begin : monitor
        bit   was;
        int   strobes;
        int   last_fs;
        obs_t cur;
        cur     = RST_OBS;
        strobes = 0;
        last_fs = -1;
        forever begin
            @(posedge clk);
            was = strb;
            @(negedge clk);
            if (!mon_en) begin
                cur     = RST_OBS;
                strobes = 0;
                last_fs = -1;
            end else begin
                if (was) begin
                    strobes++;
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL scoreboard_empty: output update with no expected entry at %0t", $time);
                    end else begin
                        cur = q.pop_front();
                    end
                end else begin
                    cur.ls = 1'b0;
                    cur.fs = 1'b0;
                end
                check("raster", act, cur);
                if (was && frame_start_o) begin
                    if (last_fs >= 0) check("frame_spacing", strobes - last_fs, HT * VT);
                    last_fs = strobes;
                end
            end
        end
    end

    initial begin : dflt
        int hs_low, vs_low, de_hi;
        hs_low = 0;
        vs_low = 0;
        de_hi  = 0;
        #20;
        @(negedge clk);
        d_rstn = 1'b1;
        @(negedge clk);
        d_strb = 1'b1;
        for (int i = 0; i < 2400; i++) begin
            @(negedge clk);
            if (d_hs == 1'b0) hs_low++;
            if (d_vs == 1'b0) vs_low++;
            if (d_de == 1'b1) de_hi++;
            if (i == 800) check("dflt_wrap_xy", {d_x, d_y}, {10'd0, 10'd1});
        end
        check("dflt_hsync_low", hs_low, 3 * 96);
        check("dflt_de_high", de_hi, 3 * 640);
        check("dflt_vsync_low", vs_low, 0);
        d_strb = 1'b0;
        d_done = 1'b1;
    end

    initial begin : stim
        mh = HT - 1;
        mv = VT - 1;
        do_reset();
        repeat (HT * VT + 1) strobe(3);
        repeat (2 * HT * VT) strobe(0);
        repeat (60) strobe(int'($urandom_range(0, 6)));
        do_reset();
        repeat (HT + 3) strobe(1);
        do_reset();
        repeat (HT + 1) strobe(2);
        repeat (3) @(negedge clk);
        check("final_queue_empty", q.size(), 0);
        for (int i = 0; i < 5000 && !d_done; i++) @(negedge clk);
        if (!d_done) begin
            checks++;
            errors++;
            $display("FAIL dflt_timeout: default-raster run did not complete");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
